bcd_to_bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter using reverse double dabble, one bit per clock.

---
 rtl/bcd_to_bin_seq.sv | 170 +++++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double dabble).
// One scratch bit is shifted per clock. A start/busy/valid handshake allows
// one conversion in flight.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   conversion request, sampled only in IDLE
//   bcdin   DIGITS x 4-bit digits, bcdin[0] = least significant digit
//   busy    high during SHIFT and DONE
//   valid   one-cycle pulse: binout/err updated this cycle
//   binout  converted value, held until the next valid
//   err     invalid-digit flag, qualified by valid
//
// Optional feature macro: BCD_DIGIT_CHECK_EN. When it is defined, a digit
// greater than 9 forces err=1 and binout=0. When it is undefined, err is
// tied to 0.
module bcd_to_bin_seq #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WIDTH  = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       bcdin [DIGITS],
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] binout,
   output logic             err
);

   localparam int unsigned BCDW = DIGITS * 4;
   localparam int unsigned SW   = BCDW + WIDTH;
   localparam int unsigned CW   = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [SW-1:0]   scratch;
   logic [CW-1:0]   count;
   logic            load_c;
   logic            shift_c;
   logic            last_c;
   logic [BCDW-1:0] bcd_packed_c;
   logic [SW-1:0]   shifted_c;
   logic [SW-1:0]   corrected_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start)  next_state = SHIFT;
         SHIFT:   if (last_c) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath control decode
   always_comb begin
      load_c  = 1'b0;
      shift_c = 1'b0;
      last_c  = 1'b0;
      case (state)
         IDLE:  load_c = start;
         SHIFT: begin
            shift_c = 1'b1;
            last_c  = (count == CW'(WIDTH - 1));
         end
         default: ;
      endcase
   end

   // Pack the digit array; digit 0 occupies the low nibble
   always_comb begin
      bcd_packed_c = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         bcd_packed_c[4*i +: 4] = bcdin[i];
      end
   end

   // One reverse-double-dabble step. The shift is followed by a nibble-local
   // correction of -3 on each digit that is >= 8. No borrow crosses digits.
   always_comb begin
      shifted_c   = scratch >> 1;
      corrected_c = shifted_c;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (shifted_c[WIDTH + 4*i +: 4] >= 4'd8) begin
            corrected_c[WIDTH + 4*i +: 4] = shifted_c[WIDTH + 4*i +: 4] - 4'd3;
         end
      end
   end

`ifdef BCD_DIGIT_CHECK_EN
   logic bad_c;
   logic err_lat;

   // Flag any digit above 9 at load time
   always_comb begin
      bad_c = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcdin[i] > 4'd9) bad_c = 1'b1;
      end
   end

   // Datapath, handshake and result registers (digit-check build)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         valid   <= 1'b0;
         binout  <= '0;
         err     <= 1'b0;
         err_lat <= 1'b0;
         scratch <= '0;
         count   <= '0;
      end else begin
         busy  <= (next_state != IDLE);
         valid <= (next_state == DONE);
         if (load_c) begin
            scratch <= {bcd_packed_c, WIDTH'(0)};
            count   <= '0;
            err_lat <= bad_c;
         end else if (shift_c) begin
            scratch <= corrected_c;
            count   <= count + CW'(1);
            if (last_c) begin
               err    <= err_lat;
               binout <= err_lat ? WIDTH'(0) : shifted_c[WIDTH-1:0];
            end
         end
      end
   end
`else
   assign err = 1'b0;

   // Datapath, handshake and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         valid   <= 1'b0;
         binout  <= '0;
         scratch <= '0;
         count   <= '0;
      end else begin
         busy  <= (next_state != IDLE);
         valid <= (next_state == DONE);
         if (load_c) begin
            scratch <= {bcd_packed_c, WIDTH'(0)};
            count   <= '0;
         end else if (shift_c) begin
            scratch <= corrected_c;
            count   <= count + CW'(1);
            if (last_c) binout <= shifted_c[WIDTH-1:0];
         end
      end
   end
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed, table-driven bench for bcd_to_bin_seq.
module tb_bcd_to_bin_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  bcdin [4];
   logic        busy;
   logic        valid;
   logic [13:0] binout;
   logic        err;

   int checks;
   int errors;

   typedef struct {
      logic [15:0] bcd;
      int          expv;
      logic        experr;
   } vec_t;

   vec_t vecs [8];

   bcd_to_bin_seq #(.DIGITS(4), .WIDTH(14)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bcdin  (bcdin),
      .busy   (busy),
      .valid  (valid),
      .binout (binout),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_bcd(input logic [15:0] v);
      for (int i = 0; i < 4; i++) bcdin[i] = v[4*i +: 4];
   endtask

   // Single conversion: start for one cycle, then check latency, result and pulse width
   task automatic run_conv(input logic [15:0] v, input int expv, input logic experr);
      int early;
      early = 0;
      @(negedge clk);
      set_bcd(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      set_bcd(16'h3333);
      chk("busy_after_start", int'(busy), 1);
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk);
         if (valid) early++;
      end
      chk("no_early_valid", early, 0);
      @(negedge clk);
      chk("valid_at_latency", int'(valid), 1);
      chk("binout", int'(binout), expv);
      chk("err", int'(err), int'(experr));
      @(negedge clk);
      chk("valid_one_cycle", int'(valid), 0);
      chk("busy_cleared", int'(busy), 0);
   endtask

   initial begin
      int vcount;
      int exp_bin;
      checks = 0;
      errors = 0;
      clk    = 1'b0;
      rst    = 1'b0;
      start  = 1'b0;
      set_bcd(16'h0000);

      vecs[0] = '{16'h9999, 9999, 1'b0};
      vecs[1] = '{16'h1234, 1234, 1'b0};
      vecs[2] = '{16'h0000,    0, 1'b0};
      vecs[3] = '{16'h0001,    1, 1'b0};
      vecs[4] = '{16'h8008, 8008, 1'b0};
      vecs[5] = '{16'h0099,   99, 1'b0};
      vecs[6] = '{16'h5555, 5555, 1'b0};
      vecs[7] = '{16'h1000, 1000, 1'b0};

      // Asynchronous reset before any clock edge
      #3 rst = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_binout", int'(binout), 0);
      chk("rst_err", int'(err), 0);
      @(negedge clk);
      rst = 1'b0;

      // Full-scale value
      run_conv(16'h9999, 9999, 1'b0);

      // Back-to-back with start held high; period is 16 cycles
      @(negedge clk);
      set_bcd(16'h1234);
      start = 1'b1;
      for (int n = 0; n <= 47; n++) begin
         @(negedge clk);
         chk("b2b_valid", int'(valid), int'((n % 16) == 14));
         chk("b2b_busy", int'(busy), int'((n % 16) != 15));
         if (n == 14) begin
            chk("b2b_bin_1234", int'(binout), 1234);
            set_bcd(16'h0000);
         end
         if (n == 30) begin
            chk("b2b_bin_0", int'(binout), 0);
            set_bcd(16'h0001);
         end
         if (n == 46) begin
            chk("b2b_bin_1", int'(binout), 1);
            start = 1'b0;
         end
      end

      // Start pulses during SHIFT and DONE are ignored; bcdin changes do not matter
      @(negedge clk);
      set_bcd(16'h4321);
      start = 1'b1;
      vcount = 0;
      for (int n = 0; n <= 30; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 1) set_bcd(16'h9999);
         if (n == 3) start = 1'b1;
         if (n == 14) begin
            chk("ign_valid", int'(valid), 1);
            chk("ign_bin", int'(binout), 4321);
            start = 1'b1;
         end
         if (valid) vcount++;
      end
      chk("ign_single_valid", vcount, 1);
      chk("ign_bin_held", int'(binout), 4321);
      chk("ign_idle", int'(busy), 0);

      // Reset 5 cycles into SHIFT abandons the conversion
      @(negedge clk);
      set_bcd(16'h7777);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_binout", int'(binout), 0);
      @(negedge clk);
      rst = 1'b0;
      vcount = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (valid) vcount++;
      end
      chk("midrst_no_valid", vcount, 0);
      chk("midrst_bin_zero", int'(binout), 0);
      run_conv(16'h0500, 500, 1'b0);

      // Illegal-digit handling
`ifdef BCD_DIGIT_CHECK_EN
      run_conv(16'h00A1, 0, 1'b1);
      run_conv(16'h0010, 10, 1'b0);
`else
      run_conv(16'h0010, 10, 1'b0);
`endif

      // Table of legal vectors
      for (int i = 0; i < 8; i++) begin
         exp_bin = vecs[i].expv;
         run_conv(vecs[i].bcd, exp_bin, vecs[i].experr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
